bus_result_capture_fifo: RTL

//  Downstream capture stage for the and2_bus result bus (ao, 6 bits).

---
 rtl/capture_pkg.sv | 24 ++
 rtl/capture_fifo_mem.sv | 34 +++
 rtl/bus_result_capture_fifo.sv | 97 +++++++++
 3 files changed

// File: rtl/capture_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : capture_pkg
//  Purpose  : Shared constants and entry-width helper for the result capture
//             FIFO. Optional feature macro: CAPTURE_PARITY_EN (adds one
//             stored parity bit per entry).
//  Revision : 1.0 - initial release
// ============================================================================
package capture_pkg;

  localparam int DEFAULT_WIDTH = 6;
  localparam int DEFAULT_DEPTH = 8;

  // Width of one stored FIFO entry: data plus the optional parity bit.
  function automatic int entry_width(input int width);
`ifdef CAPTURE_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage : capture_pkg
`default_nettype wire

// File: rtl/capture_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module   : capture_fifo_mem
//  Purpose  : DEPTH x EW register array with one synchronous write port and
//             one asynchronous read port. Contents are not reset; validity is
//             tracked by the pointers in the parent.
//  Revision : 1.0 - initial release
// ============================================================================
module capture_fifo_mem #(
  parameter  int DEPTH = 8,
  parameter  int EW    = 6,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [EW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [EW-1:0] rdata
);

  logic [EW-1:0] r_mem [DEPTH];

  // Store the incoming entry at the write address.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule : capture_fifo_mem
`default_nettype wire

// File: rtl/bus_result_capture_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : bus_result_capture_fifo
//  Purpose  : Capture stage for the and2_bus result bus. Buffers valid
//             results in a show-ahead FIFO behind a valid/ready handshake and
//             flags (sticky) any push attempted while full.
//             Optional feature macro: CAPTURE_PARITY_EN (per-entry parity,
//             checked on the head entry).
//  Revision : 1.0 - initial release
// ============================================================================
module bus_result_capture_fifo
  import capture_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             parity_err
);

  localparam int EW = entry_width(WIDTH);

  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          r_overflow;
  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic [EW-1:0] w_wdata;
  logic [EW-1:0] w_rdata;

  // Extra pointer MSB distinguishes full from empty when low bits match.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                   (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_push  = in_valid && !w_full;
  assign w_pop   = out_ready && !w_empty;

  // Pointer advance and sticky overflow capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (in_valid && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

`ifdef CAPTURE_PARITY_EN
  assign w_wdata    = {^in_data, in_data};
  assign parity_err = !w_empty && (w_rdata[WIDTH] != ^w_rdata[WIDTH-1:0]);
`else
  assign w_wdata    = in_data;
  assign parity_err = 1'b0;
`endif

  capture_fifo_mem #(
    .DEPTH (DEPTH),
    .EW    (EW)
  ) u_mem (
    .clk   (clk),
    .we    (w_push),
    .waddr (r_wr_ptr[AW-1:0]),
    .wdata (w_wdata),
    .raddr (r_rd_ptr[AW-1:0]),
    .rdata (w_rdata)
  );

  assign in_ready  = !w_full;
  assign out_valid = !w_empty;
  // Head is masked to zero while empty so stale storage never shows.
  assign out_data  = w_empty ? '0 : w_rdata[WIDTH-1:0];
  assign count     = r_wr_ptr - r_rd_ptr;
  assign overflow  = r_overflow;

endmodule : bus_result_capture_fifo
`default_nettype wire
